// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU result serializer.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        TYPE  = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam int unsigned FRAME_LEN   = 11;
    localparam logic        TYPE_DATA   = 1'b0;
    localparam logic        TYPE_CMD    = 1'b1;
    localparam int unsigned DATA_FRAMES = 4;
    localparam int unsigned CTL_ERR_BIT = 7;

    // Byte idx of the result word, most significant byte first.
    function automatic logic [7:0] frame_byte(input logic [31:0] c, input logic [2:0] idx);
        case (idx)
            3'd0:    return c[31:24];
            3'd1:    return c[23:16];
            3'd2:    return c[15:8];
            default: return c[7:0];
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Result/status handshake between the ALU core and the serializer.
interface mtm_alu_serializer_if;
    logic        valid;
    logic [31:0] C;
    logic [7:0]  CTL_in;
    logic        sout;
    logic        busy;

    modport master (output valid, output C, output CTL_in, input sout, input busy);
    modport slave  (input valid, input C, input CTL_in, output sout, output busy);
endinterface

// File: rtl/mtm_alu_frame_tx.sv
// Shifts one 11-bit frame: start 0, type bit, data MSB first, stop 1.
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       type_bit,
    input  logic [7:0] data,
    output logic       sout,
    output logic       frame_done
);

    tx_state_t  state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       type_q;

    assign frame_done = (state == STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            type_q  <= 1'b0;
            sout    <= 1'b1;
        end else begin
            case (state)
                // A load during STOP chains the next frame with no idle bit.
                IDLE, STOP: begin
                    if (load) begin
                        state  <= START;
                        sout   <= 1'b0;
                        shreg  <= data;
                        type_q <= type_bit;
                    end else begin
                        state <= IDLE;
                        sout  <= 1'b1;
                    end
                end
                START: begin
                    state <= TYPE;
                    sout  <= type_q;
                end
                TYPE: begin
                    state <= DATA;
                    sout  <= shreg[7];
                    shreg <= {shreg[6:0], 1'b0};
                end
                DATA: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= STOP;
                        sout  <= 1'b1;
                    end else begin
                        sout  <= shreg[7];
                        shreg <= {shreg[6:0], 1'b0};
                    end
                end
                default: begin
                    state <= IDLE;
                    sout  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Serializes an ALU result as 4 DATA frames + 1 CMD frame, or a lone CMD
// frame when the status byte flags an error/echo.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mtm_alu_serializer_if.slave bus
);

    logic        busy_q;
    logic [31:0] c_q;
    logic [7:0]  ctl_q;
    logic [2:0]  frame_cnt;
    logic [2:0]  next_idx;
    logic        accept;
    logic        more;
    logic        advance;
    logic        load;
    logic        type_bit;
    logic [7:0]  data;
    logic        tx_sout;
    logic        tx_done;

    assign accept   = bus.valid && !busy_q;
    assign more     = !ctl_q[CTL_ERR_BIT] && (frame_cnt < 3'(DATA_FRAMES));
    assign advance  = busy_q && tx_done && more;
    assign next_idx = frame_cnt + 3'd1;

    // The first frame is taken straight from the bus since the latches
    // only update on the accepting edge.
    always_comb begin
        load     = accept || advance;
        type_bit = TYPE_DATA;
        data     = '0;
        if (accept) begin
            if (bus.CTL_in[CTL_ERR_BIT]) begin
                type_bit = TYPE_CMD;
                data     = bus.CTL_in;
            end else begin
                data = bus.C[31:24];
            end
        end else if (next_idx == 3'(DATA_FRAMES)) begin
            type_bit = TYPE_CMD;
            data     = ctl_q;
        end else begin
            data = frame_byte(c_q, next_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            c_q       <= '0;
            ctl_q     <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            busy_q    <= 1'b1;
            c_q       <= bus.C;
            ctl_q     <= bus.CTL_in;
            frame_cnt <= '0;
        end else if (busy_q && tx_done) begin
            if (more) begin
                frame_cnt <= next_idx;
            end else begin
                busy_q    <= 1'b0;
                frame_cnt <= '0;
            end
        end
    end

    mtm_alu_frame_tx u_frame_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .type_bit   (type_bit),
        .data       (data),
        .sout       (tx_sout),
        .frame_done (tx_done)
    );

    assign bus.sout = tx_sout;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer against a bit-queue packet model.
module tb_mtm_alu_serializer;

    logic clk = 1'b0;
    logic rst;

    mtm_alu_serializer_if bus ();

    mtm_alu_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_q[$];

    function automatic void push_frame(input bit t, input logic [7:0] b);
        exp_q.push_back(1'b0);
        exp_q.push_back(t);
        for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
        exp_q.push_back(1'b1);
    endfunction

    function automatic void build_model(input logic [31:0] c, input logic [7:0] ctl);
        exp_q.delete();
        if (ctl[7] == 1'b0) begin
            for (int k = 0; k < 4; k++) push_frame(1'b0, 8'(c >> (24 - 8 * k)));
        end
        push_frame(1'b1, ctl);
    endfunction

    // Called at a negedge; valid goes high immediately so back-to-back calls
    // exercise the earliest legal accept.
    task automatic run_packet(input logic [31:0] c, input logic [7:0] ctl,
                              input int inj, input bit inj_rst, input string name);
        build_model(c, ctl);
        bus.valid  = 1'b1;
        bus.C      = c;
        bus.CTL_in = ctl;
        @(negedge clk);
        bus.valid  = 1'b0;
        bus.C      = $urandom;
        bus.CTL_in = 8'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if ({bus.sout, bus.busy} !== {exp_q[i], 1'b1}) begin
                n_fail++;
                $display("FAIL %s bit %0d: sout,busy=%b%b expected %b1",
                         name, i, bus.sout, bus.busy, exp_q[i]);
            end
            if (i == inj) begin
                if (inj_rst) rst = 1'b1;
                else begin
                    bus.valid = 1'b1;
                    bus.C     = '1;
                end
            end
            @(negedge clk);
            bus.valid = 1'b0;
            if (rst) begin
                rst = 1'b0;
                n_cmp++;
                if ({bus.sout, bus.busy} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL %s abort: sout,busy=%b%b expected 10", name, bus.sout, bus.busy);
                end
                return;
            end
        end
        n_cmp++;
        if ({bus.sout, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s end: sout,busy=%b%b expected 10", name, bus.sout, bus.busy);
        end
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.sout, bus.busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s idle %0d: sout,busy=%b%b expected 10", name, i, bus.sout, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.valid  = 1'b1;
        bus.C      = 32'h12345678;
        bus.CTL_in = 8'h0B;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.sout, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_with_valid: sout,busy=%b%b expected 10", bus.sout, bus.busy);
        end
        rst       = 1'b0;
        bus.valid = 1'b0;
        idle(3, "after_reset");
    endtask

    task automatic test_normal();
        run_packet(32'h12345678, 8'h0B, -1, 1'b0, "normal");
        idle(2, "normal_gap");
    endtask

    task automatic test_error();
        run_packet($urandom, 8'h93, -1, 1'b0, "error");
        idle(2, "error_gap");
    endtask

    task automatic test_echo();
        run_packet($urandom, 8'hA5, -1, 1'b0, "echo");
        idle(2, "echo_gap");
    endtask

    task automatic test_busy_ignore();
        run_packet(32'h12345678, 8'h0B, 10, 1'b0, "busy_ignore");
        idle(20, "no_extra_packet");
    endtask

    task automatic test_mid_reset();
        run_packet(32'h12345678, 8'h0B, 20, 1'b1, "mid_reset");
        idle(3, "post_abort");
        run_packet(32'h00000000, 8'h10, -1, 1'b0, "after_abort");
        idle(2, "after_abort_gap");
    endtask

    task automatic test_back_to_back();
        run_packet(32'hDEADBEEF, 8'h2C, -1, 1'b0, "b2b_first");
        run_packet(32'hCAFEF00D, 8'h81, -1, 1'b0, "b2b_second");
        run_packet(32'h0F0F0F0F, 8'h7E, -1, 1'b0, "b2b_third");
        idle(2, "b2b_gap");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_packet($urandom, 8'($urandom), -1, 1'b0, "random");
            idle(int'($urandom_range(0, 3)), "random_gap");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.valid  = 1'b0;
        bus.C      = '0;
        bus.CTL_in = '0;
        test_reset();
        test_normal();
        test_error();
        test_echo();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
